// File: rtl/output_credit_tx_pkg.sv
// output_credit_tx_pkg: link flit types, per-VC packet state and label legality helpers
package output_credit_tx_pkg;
  localparam int VC_NUM = 2;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W = 14;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef struct packed {
    flit_label_t label;
    logic [DATA_W-1:0] data;
  } flit_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} vc_state_t;
  function automatic logic label_legal(vc_state_t s, flit_label_t l);
    return (s == IDLE) ? (l == HEAD || l == HEADTAIL) : (s == ACTIVE) ? (l == BODY || l == TAIL) : 1'b0;
  endfunction
  function automatic vc_state_t next_state(flit_label_t l);
    return (l == HEADTAIL || l == TAIL) ? DRAIN : ACTIVE;
  endfunction
endpackage

// File: rtl/output_credit_tx_credit_counter.sv
// credit_counter: free-slot count of one downstream VC buffer
module credit_counter #(
  parameter int BUFFER_SIZE = 8,
  parameter int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          is_full_o,
  output logic          is_zero_o,
  output logic          overflow_o
);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);
  logic [CW-1:0] r_count;
  assign count_o = r_count;
  assign is_full_o = r_count == FULL;
  assign is_zero_o = r_count == '0;
  assign overflow_o = inc_i & is_full_o;
  // Net effect of a send and a return; a lone return at full saturates
  always_ff @(posedge clk)
    if (rst) r_count <= FULL;
    else if (dec_i & ~inc_i) r_count <= r_count - 1'b1;
    else if (inc_i & ~dec_i & ~is_full_o) r_count <= r_count + 1'b1;
endmodule

// File: rtl/output_credit_tx.sv
// output_credit_tx: credit-gated link transmitter with per-VC packet tracking
module output_credit_tx #(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM = output_credit_tx_pkg::VC_NUM,
  parameter int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  output_credit_tx_pkg::flit_t flit_i,
  input  logic [VC_SIZE-1:0]          vc_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output output_credit_tx_pkg::flit_t flit_o,
  output logic [VC_SIZE-1:0]          vc_o,
  output logic                        valid_o,
  input  logic                        credit_valid_i,
  input  logic [VC_SIZE-1:0]          credit_vc_i,
  output logic [VC_NUM-1:0]           has_credit_o,
  output logic [VC_NUM-1:0]           vc_free_o,
  output logic                        error_o
);
  import output_credit_tx_pkg::*;
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  logic [VC_NUM-1:0] w_dec, w_inc, w_full, w_zero, w_ovf, w_drained;
  logic [CW-1:0] w_cnt [VC_NUM];
  vc_state_t r_state [VC_NUM];
  vc_state_t w_cur;
  logic w_vc_ok, w_legal, w_accept, w_fire;
  logic r_valid, r_err;
  flit_t r_flit;
  logic [VC_SIZE-1:0] r_vc;
  assign w_vc_ok = int'(vc_i) < VC_NUM;
  assign ready_o = w_vc_ok ? ~w_zero[vc_i] : 1'b0;
  assign w_cur = w_vc_ok ? r_state[vc_i] : DRAIN;
  assign w_legal = w_vc_ok & label_legal(w_cur, flit_i.label);
  assign w_accept = valid_i & ready_o;
  assign w_fire = w_accept & w_legal;
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_dec[v] = w_fire & (vc_i == VC_SIZE'(v));
    assign w_inc[v] = credit_valid_i & (credit_vc_i == VC_SIZE'(v));
    assign w_drained[v] = w_full[v] | ((w_cnt[v] == CW'(BUFFER_SIZE - 1)) & w_inc[v]);
    assign has_credit_o[v] = ~w_zero[v];
    assign vc_free_o[v] = r_state[v] == IDLE;
    credit_counter #(.BUFFER_SIZE(BUFFER_SIZE), .CW(CW)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .dec_i     (w_dec[v]),
      .inc_i     (w_inc[v]),
      .count_o   (w_cnt[v]),
      .is_full_o (w_full[v]),
      .is_zero_o (w_zero[v]),
      .overflow_o(w_ovf[v])
    );
  end
  // Per-VC packet state: advance on sent flits, release DRAIN as the last credit comes home
  always_ff @(posedge clk)
    for (int v = 0; v < VC_NUM; v++)
      if (rst) r_state[v] <= IDLE;
      else if (w_dec[v]) r_state[v] <= next_state(flit_i.label);
      else if (r_state[v] == DRAIN && w_drained[v]) r_state[v] <= IDLE;
  // Link register and one-cycle error pulse; flit/vc hold when nothing is sent
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_err <= 1'b0;
      r_flit <= '0;
      r_vc <= '0;
    end else begin
      r_valid <= w_fire;
      r_err <= (w_accept & ~w_legal) | (valid_i & ~w_vc_ok) | (|w_ovf);
      if (w_fire) begin
        r_flit <= flit_i;
        r_vc <= vc_i;
      end
    end
  assign valid_o = r_valid;
  assign error_o = r_err;
  assign flit_o = r_flit;
  assign vc_o = r_vc;
endmodule
